branch_predict_ctrl: RTL

- Direction predictor and branch-resolution controller for the 5-stage pipeline.
- Holds a table of 2-bit saturating counters indexed by PC, giving the IF stage a taken/not-taken hint.
- Compares the EX-stage branch outcome with the prediction carried down the pipe.
- On a mismatch, or on any JAL/JALR, issues a registered PC redirect and a multi-cycle flush. The flush drives the flush input of the EX branch-condition logic and the IF/ID pipeline registers.

---
 rtl/branch_predict_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/branch_predict_ctrl.sv
// ---------------------------------------------------------------------------
// branch_predict_ctrl : 2-bit direction predictor + EX branch resolve/redirect
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module branch_predict_ctrl #(
  parameter int IDX_W        = 6,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_if_valid,
  input  logic [31:0] i_if_pc,
  output logic        o_pred_taken,
  input  logic        i_ex_valid,
  input  logic [31:0] i_ex_pc,
  input  logic        i_ex_is_cond,
  input  logic        i_ex_is_jump,
  input  logic        i_ex_taken,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_target,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_flush,
  output logic [31:0] o_mispredict_cnt
);

  localparam int         c_ENTRIES    = 1 << IDX_W;
  localparam logic [3:0] c_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_fcnt;
  logic [3:0]        w_fcnt_nxt;
  logic              w_flush;

  logic [1:0]        r_table [c_ENTRIES];
  logic              r_redirect;
  logic [31:0]       r_redirect_pc;
  logic [31:0]       r_mis_cnt;

  logic [IDX_W-1:0]  w_if_idx;
  logic [IDX_W-1:0]  w_ex_idx;
  logic              w_live;
  logic              w_upd;
  logic              w_cond_mis;
  logic              w_mis;
  logic [1:0]        w_ctr_cur;
  logic [1:0]        w_ctr_nxt;
  logic [31:0]       w_redirect_pc;
  logic              w_unused;

  assign w_if_idx = i_if_pc[IDX_W+1:2];
  assign w_ex_idx = i_ex_pc[IDX_W+1:2];

  // Fetch bits outside the index carry no information for the table.
  assign w_unused = &{1'b0, i_if_pc[31:IDX_W+2], i_if_pc[1:0]};

  assign o_pred_taken = i_if_valid & r_table[w_if_idx][1];

  // EX contents are squashed while flushing, so they must not train or redirect.
  assign w_live     = i_ex_valid & ~w_flush;
  assign w_upd      = w_live & i_ex_is_cond & ~i_ex_is_jump;
  assign w_cond_mis = w_upd & (i_ex_taken != i_ex_pred_taken);
  assign w_mis      = w_live & ((i_ex_is_cond & (i_ex_taken != i_ex_pred_taken)) | i_ex_is_jump);

  assign w_redirect_pc = (i_ex_is_jump | i_ex_taken) ? i_ex_target : (i_ex_pc + 32'd4);

  always_comb begin
    w_ctr_cur = r_table[w_ex_idx];
    w_ctr_nxt = w_ctr_cur;
    if (i_ex_taken) begin
      if (w_ctr_cur != 2'b11) w_ctr_nxt = w_ctr_cur + 2'd1;
    end else begin
      if (w_ctr_cur != 2'b00) w_ctr_nxt = w_ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_ENTRIES; i++) begin
        r_table[i] <= 2'b01;
      end
    end else if (w_upd) begin
      r_table[w_ex_idx] <= w_ctr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect    <= 1'b0;
      r_redirect_pc <= 32'd0;
      r_mis_cnt     <= 32'd0;
    end else begin
      r_redirect <= w_mis;
      if (w_mis) begin
        r_redirect_pc <= w_redirect_pc;
      end
      if (w_cond_mis) begin
        r_mis_cnt <= r_mis_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_fcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    w_flush     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mis) begin
          w_state_nxt = S_FLUSH;
          w_fcnt_nxt  = c_FLUSH_LOAD;
        end
      end
      S_FLUSH: begin
        w_flush = 1'b1;
        if (r_fcnt == 4'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_fcnt_nxt = r_fcnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_fcnt_nxt  = 4'd0;
      end
    endcase
  end

  assign o_redirect       = r_redirect;
  assign o_redirect_pc    = r_redirect_pc;
  assign o_flush          = w_flush;
  assign o_mispredict_cnt = r_mis_cnt;

endmodule

`default_nettype wire
